// File: rtl/vga_timing_pkg.sv
// Shared types, resolution presets and decode helpers for the VGA raster timing generator.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_t;

    // VESA 1280x800@60
    localparam int unsigned P1280X800_H_ACTIVE = 1280;
    localparam int unsigned P1280X800_H_FP     = 72;
    localparam int unsigned P1280X800_H_SYNC   = 128;
    localparam int unsigned P1280X800_H_BP     = 200;
    localparam int unsigned P1280X800_V_ACTIVE = 800;
    localparam int unsigned P1280X800_V_FP     = 3;
    localparam int unsigned P1280X800_V_SYNC   = 6;
    localparam int unsigned P1280X800_V_BP     = 22;
    localparam bit          P1280X800_H_POL    = 1'b0;
    localparam bit          P1280X800_V_POL    = 1'b1;

    // Industry-standard 640x480@60
    localparam int unsigned P640X480_H_ACTIVE = 640;
    localparam int unsigned P640X480_H_FP     = 16;
    localparam int unsigned P640X480_H_SYNC   = 96;
    localparam int unsigned P640X480_H_BP     = 48;
    localparam int unsigned P640X480_V_ACTIVE = 480;
    localparam int unsigned P640X480_V_FP     = 10;
    localparam int unsigned P640X480_V_SYNC   = 2;
    localparam int unsigned P640X480_V_BP     = 33;
    localparam bit          P640X480_H_POL    = 1'b0;
    localparam bit          P640X480_V_POL    = 1'b0;

    // Sync pin level for a given phase and active polarity.
    function automatic logic sync_level(input phase_t ph, input logic pol);
        return (ph == PH_SYNC) ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
// Exposes the next phase so the parent can register decodes on the same edge as pos.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = 8,
    parameter int unsigned FP     = 2,
    parameter int unsigned SYNC   = 3,
    parameter int unsigned BP     = 2,
    localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP,
    localparam int unsigned PW    = $clog2(TOTAL)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          advance,
    output logic [PW-1:0] pos,
    output phase_t        phase,
    output logic          wrap,
    output phase_t        phase_nxt_c
);

    localparam int unsigned ACTIVE_END = ACTIVE - 1;
    localparam int unsigned FRONT_END  = ACTIVE + FP - 1;
    localparam int unsigned SYNC_END   = ACTIVE + FP + SYNC - 1;
    localparam int unsigned LAST       = TOTAL - 1;

    if (ACTIVE == 0 || SYNC == 0) begin : g_bad_geometry
        $error("vga_axis_counter: ACTIVE and SYNC must both be at least 1");
    end

    logic [PW-1:0] pos_nxt_c;

    // Next position and phase; a zero-length porch is skipped on the way through.
    always_comb begin
        pos_nxt_c   = pos;
        phase_nxt_c = phase;
        if (advance) begin
            pos_nxt_c = (pos == PW'(LAST)) ? '0 : pos + PW'(1);
            case (phase)
                PH_ACTIVE: if (pos == PW'(ACTIVE_END)) phase_nxt_c = (FP != 0) ? PH_FRONT : PH_SYNC;
                PH_FRONT:  if (pos == PW'(FRONT_END))  phase_nxt_c = PH_SYNC;
                PH_SYNC:   if (pos == PW'(SYNC_END))   phase_nxt_c = (BP != 0) ? PH_BACK : PH_ACTIVE;
                PH_BACK:   if (pos == PW'(LAST))       phase_nxt_c = PH_ACTIVE;
                default:                               phase_nxt_c = PH_BACK;
            endcase
        end
    end

    // Reset parks the axis on its last count so the first advance lands on 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos   <= PW'(LAST);
            phase <= PH_BACK;
            wrap  <= 1'b1;
        end else begin
            pos   <= pos_nxt_c;
            phase <= phase_nxt_c;
            wrap  <= (pos_nxt_c == PW'(LAST));
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator (syncs, active flag, coordinates, strobes).
// Define VGA_TIMING_FRAMECNT_EN to add a 16-bit completed-frame counter output.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = P1280X800_H_ACTIVE,
    parameter int unsigned H_FP       = P1280X800_H_FP,
    parameter int unsigned H_SYNC     = P1280X800_H_SYNC,
    parameter int unsigned H_BP       = P1280X800_H_BP,
    parameter int unsigned V_ACTIVE   = P1280X800_V_ACTIVE,
    parameter int unsigned V_FP       = P1280X800_V_FP,
    parameter int unsigned V_SYNC     = P1280X800_V_SYNC,
    parameter int unsigned V_BP       = P1280X800_V_BP,
    parameter bit          H_SYNC_POL = P1280X800_H_POL,
    parameter bit          V_SYNC_POL = P1280X800_V_POL,
    localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned HW        = $clog2(H_TOTAL),
    localparam int unsigned VW        = $clog2(V_TOTAL)
) (
    input  logic          vgaclk,
    input  logic          reset,
    input  logic          enable,
    output logic          hsync,
    output logic          vsync,
    output logic          active,
    output logic [HW-1:0] x,
    output logic [VW-1:0] y,
    output logic          line_start,
    output logic          frame_start
`ifdef VGA_TIMING_FRAMECNT_EN
    ,
    output logic [15:0]   frame_count
`endif
);

    logic   h_wrap;
    logic   v_wrap;
    logic   v_advance_c;
    phase_t h_phase;
    phase_t v_phase;
    phase_t h_phase_nxt_c;
    phase_t v_phase_nxt_c;

    // The line counter only steps as the pixel counter rolls over.
    assign v_advance_c = enable & h_wrap;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk         (vgaclk),
        .reset       (reset),
        .advance     (enable),
        .pos         (x),
        .phase       (h_phase),
        .wrap        (h_wrap),
        .phase_nxt_c (h_phase_nxt_c)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk         (vgaclk),
        .reset       (reset),
        .advance     (v_advance_c),
        .pos         (y),
        .phase       (v_phase),
        .wrap        (v_wrap),
        .phase_nxt_c (v_phase_nxt_c)
    );

    // Decodes are taken from next state so they change on the same edge as x/y.
    always_ff @(posedge vgaclk or negedge reset) begin
        if (!reset) begin
            hsync       <= ~H_SYNC_POL;
            vsync       <= ~V_SYNC_POL;
            active      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (enable) begin
            hsync       <= sync_level(h_phase_nxt_c, H_SYNC_POL);
            vsync       <= sync_level(v_phase_nxt_c, V_SYNC_POL);
            active      <= (h_phase_nxt_c == PH_ACTIVE) && (v_phase_nxt_c == PH_ACTIVE);
            line_start  <= h_wrap;
            frame_start <= h_wrap & v_wrap;
        end
    end

`ifdef VGA_TIMING_FRAMECNT_EN
    logic first_seen;

    // The frame that starts right after reset is not yet complete, so it is not counted.
    always_ff @(posedge vgaclk or negedge reset) begin
        if (!reset) begin
            first_seen  <= 1'b0;
            frame_count <= '0;
        end else if (enable && h_wrap && v_wrap) begin
            first_seen <= 1'b1;
            if (first_seen) frame_count <= frame_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a 15x8 raster, both sync polarity settings.
module tb_vga_timing_gen;

    typedef struct {
        int   x;
        int   y;
        logic ls;
        logic fs;
        logic rst;
        int   mode;
        int   fc;
    } exp_t;

    logic clk;
    logic reset;
    logic enable;

    logic       hs_a, vs_a, act_a, ls_a, fs_a;
    logic [3:0] x_a;
    logic [2:0] y_a;
    logic       hs_b, vs_b, act_b, ls_b, fs_b;
    logic [3:0] x_b;
    logic [2:0] y_b;
`ifdef VGA_TIMING_FRAMECNT_EN
    logic [15:0] fc_a, fc_b;
`endif

    int total;
    int bad;
    exp_t q[$];

    // Bench-side raster model state
    int   mx, my, mfc;
    logic mls, mfs, started;

    // Monitor state
    exp_t e;
    int   cycle;
    int   last_mark;
    int   last_mode;
    logic prev_fs;
    logic exp_hs_a, exp_vs_a, exp_act;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b1)
    ) dut_a (
        .vgaclk(clk), .reset(reset), .enable(enable),
        .hsync(hs_a), .vsync(vs_a), .active(act_a), .x(x_a), .y(y_a),
        .line_start(ls_a), .frame_start(fs_a)
`ifdef VGA_TIMING_FRAMECNT_EN
        , .frame_count(fc_a)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0)
    ) dut_b (
        .vgaclk(clk), .reset(reset), .enable(enable),
        .hsync(hs_b), .vsync(vs_b), .active(act_b), .x(x_b), .y(y_b),
        .line_start(ls_b), .frame_start(fs_b)
`ifdef VGA_TIMING_FRAMECNT_EN
        , .frame_count(fc_b)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus at the falling edge and queue what the next rising edge must produce.
    task automatic cyc(input logic r, input logic en, input int mode);
        exp_t n;
        @(negedge clk);
        reset  = r;
        enable = en;
        if (!r) begin
            mx = 14; my = 7; mls = 1'b0; mfs = 1'b0; started = 1'b0; mfc = 0;
        end else if (en) begin
            mls = (mx == 14);
            mfs = (mx == 14) && (my == 7);
            if (mx == 14) begin
                mx = 0;
                my = (my == 7) ? 0 : my + 1;
            end else begin
                mx = mx + 1;
            end
            if (mfs) begin
                if (started) mfc = (mfc + 1) & 32'hFFFF;
                started = 1'b1;
            end
        end
        n.x = mx; n.y = my; n.ls = mls; n.fs = mfs; n.rst = r; n.mode = mode; n.fc = mfc;
        q.push_back(n);
    endtask

    // Monitor: one queued expectation per rising edge, plus frame_start period measurement.
    initial begin
        cycle = 0; last_mark = -1; last_mode = 0; prev_fs = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (q.size() > 0) begin
                e = q.pop_front();
                // Hand-derived windows: hsync pulse x=10..12, vsync pulse y=5..6, visible x<8,y<4
                exp_hs_a = !(e.x >= 10 && e.x <= 12);
                exp_vs_a = (e.y >= 5 && e.y <= 6);
                exp_act  = (e.x < 8) && (e.y < 4);
                chk("a.x", 32'(x_a), e.x);
                chk("a.y", 32'(y_a), e.y);
                chk("a.hsync", 32'(hs_a), 32'(exp_hs_a));
                chk("a.vsync", 32'(vs_a), 32'(exp_vs_a));
                chk("a.active", 32'(act_a), 32'(exp_act));
                chk("a.line_start", 32'(ls_a), 32'(e.ls));
                chk("a.frame_start", 32'(fs_a), 32'(e.fs));
                chk("b.x", 32'(x_b), e.x);
                chk("b.y", 32'(y_b), e.y);
                chk("b.hsync", 32'(hs_b), 32'(!exp_hs_a));
                chk("b.vsync", 32'(vs_b), 32'(!exp_vs_a));
                chk("b.active", 32'(act_b), 32'(exp_act));
                chk("b.line_start", 32'(ls_b), 32'(e.ls));
                chk("b.frame_start", 32'(fs_b), 32'(e.fs));
`ifdef VGA_TIMING_FRAMECNT_EN
                chk("a.frame_count", 32'(fc_a), e.fc);
                chk("b.frame_count", 32'(fc_b), e.fc);
`endif
                if (!e.rst) begin
                    last_mark = -1;
                end else if (fs_a && !prev_fs) begin
                    if (last_mark >= 0 && last_mode == e.mode && e.mode != 0)
                        chk("frame_period", 32'(cycle - last_mark), 32'(120 * e.mode));
                    last_mark = cycle;
                    last_mode = e.mode;
                end
                prev_fs = fs_a;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        total = 0; bad = 0;
        reset = 1'b0; enable = 1'b0;
        mx = 14; my = 7; mfc = 0; mls = 1'b0; mfs = 1'b0; started = 1'b0;

        // Reset held, then free run for two frames
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 0);
        for (int i = 0; i < 240; i++) cyc(1'b1, 1'b1, 1);

        // Alternating enable: two frames of enabled pixels over 480 cycles
        for (int i = 0; i < 480; i++) cyc(1'b1, (i % 2) == 0, 2);

        // Walk to (6,2), then hit reset away from any clock edge
        for (int i = 0; i < 200 && !(mx == 6 && my == 2); i++) cyc(1'b1, 1'b1, 1);
        @(posedge clk);
        #2;
        chk("pre_reset.x", 32'(x_a), 32'd6);
        chk("pre_reset.y", 32'(y_a), 32'd2);
        #1;
        reset = 1'b0;
        #1;
        chk("async_reset.x", 32'(x_a), 32'd14);
        chk("async_reset.y", 32'(y_a), 32'd7);
        chk("async_reset.hsync_a", 32'(hs_a), 32'd1);
        chk("async_reset.vsync_a", 32'(vs_a), 32'd0);
        chk("async_reset.hsync_b", 32'(hs_b), 32'd0);
        chk("async_reset.vsync_b", 32'(vs_b), 32'd1);
        chk("async_reset.active", 32'(act_a), 32'd0);
        chk("async_reset.line_start", 32'(ls_a), 32'd0);
        chk("async_reset.frame_start", 32'(fs_a), 32'd0);

        // Restart and run just over three frames
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 0);
        for (int i = 0; i < 370; i++) cyc(1'b1, 1'b1, 1);

        @(posedge clk);
        #3;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
